// File: rtl/twiddle_gen_par_pkg.sv
// Shared constants, types and the twiddle table builder for the parallel FFT twiddle generator.
package twiddle_gen_par_pkg;

    localparam int unsigned TW_N     = 128;
    localparam int unsigned TW_LOG2N = 7;
    localparam int unsigned TW_LANES = 4;
    localparam int unsigned TW_DW    = 11;
    localparam real         TW_PI    = 3.14159265358979323846;

    typedef struct packed {
        logic signed [TW_DW-1:0] re;
        logic signed [TW_DW-1:0] im;
    } coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // One component of W^k: round(S*cos(2*pi*k/n)) or round(-S*sin(2*pi*k/n)), S = 2^(dw-1)-1.
    // Series evaluation keeps this usable as an elaboration-time constant function.
    function automatic int twiddle_comp(int unsigned k, int unsigned n, int unsigned dw, bit imag);
        real ang;
        real x2;
        real term;
        real acc;
        real v;
        ang  = 2.0 * TW_PI * real'(k) / real'(n);
        x2   = ang * ang;
        term = imag ? ang : 1.0;
        acc  = 0.0;
        for (int unsigned i = 0; i < 30; i++) begin
            acc  = acc + term;
            term = imag ? -term * x2 / real'((2*i + 2) * (2*i + 3))
                        : -term * x2 / real'((2*i + 1) * (2*i + 2));
        end
        v = real'((1 << (dw - 1)) - 1) * (imag ? -acc : acc);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/twiddle_gen_par_if.sv
// Control/coefficient bundle between the FFT control FSM (master) and the twiddle generator (slave).
interface twiddle_gen_par_if
    import twiddle_gen_par_pkg::*;
#(
    parameter int unsigned LOG2N = TW_LOG2N,
    parameter int unsigned LANES = TW_LANES,
    parameter int unsigned DW    = TW_DW
);
    logic                    start;
    logic [LOG2N-1:0]        stage;
    logic                    hold;
    logic                    busy;
    logic [LANES*2*DW-1:0]   coeff_out;
    logic                    coeff_valid;
    logic                    coeff_last;
    logic                    err;

    modport master (
        output start, stage, hold,
        input  busy, coeff_out, coeff_valid, coeff_last, err
    );

    modport slave (
        input  start, stage, hold,
        output busy, coeff_out, coeff_valid, coeff_last, err
    );
endinterface

// File: rtl/twiddle_gen_par_rom_bank.sv
// Single-port twiddle ROM, N/2 words of {re,im}, registered read with synchronous clear.
module twiddle_gen_par_rom_bank
    import twiddle_gen_par_pkg::*;
#(
    parameter  int unsigned N  = TW_N,
    parameter  int unsigned DW = TW_DW,
    localparam int unsigned AW = $clog2(N / 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [2*DW-1:0] rd_data
);

    logic [2*DW-1:0] rom [N/2];

    // Table contents are fixed at elaboration from the Q1.(DW-1) rounding rule.
    for (genvar i = 0; i < N/2; i++) begin : g_word
        localparam int RE = twiddle_comp(i, N, DW, 1'b0);
        localparam int IM = twiddle_comp(i, N, DW, 1'b1);
        assign rom[i] = {RE[DW-1:0], IM[DW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (en) begin
            rd_data <= rom[addr];
        end
    end

endmodule

// File: rtl/twiddle_gen_par.sv
// Parallel twiddle generator: LANES ROM ports, stage-dependent stride, start/hold handshake, last flag.
module twiddle_gen_par
    import twiddle_gen_par_pkg::*;
#(
    parameter int unsigned N     = TW_N,
    parameter int unsigned LOG2N = TW_LOG2N,
    parameter int unsigned LANES = TW_LANES,
    parameter int unsigned DW    = TW_DW
) (
    input  logic              clk,
    input  logic              rst,
    twiddle_gen_par_if.slave  bus
);

    localparam int unsigned AW    = $clog2(N / 2);
    localparam int unsigned BEATS = N / (2 * LANES);
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0]    LAST_CNT  = CW'(BEATS - 1);
    localparam logic [AW-1:0]    IDX_MASK  = '1;
    localparam logic [LOG2N-1:0] STAGE_LIM = LOG2N[LOG2N-1:0];

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [LOG2N-1:0] s_q;
    logic            issue;
    logic            start_ok;
    logic            valid_q;
    logic            last_q;
    logic            err_q;
    logic [2*DW-1:0] lane_data [LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
            ST_RUN:   if (!bus.hold && cnt == LAST_CNT) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.hold) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != ST_IDLE);
        issue    = (state == ST_RUN) && !bus.hold;
        start_ok = bus.start && (state == ST_IDLE) && (bus.stage < STAGE_LIM);
    end

    // hold freezes the counter and the valid/last pipeline together with the ROM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.start && !start_ok;
            if (start_ok) begin
                s_q <= bus.stage;
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + 1'b1;
            end
            if (!bus.hold) begin
                valid_q <= issue;
                last_q  <= issue && (cnt == LAST_CNT);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [AW-1:0] j;
        logic [AW-1:0] k;

        // k = (j mod M) << s with M = N >> (s+1), done as a mask since M is a power of two.
        always_comb begin
            j = AW'(cnt) * AW'(LANES) + AW'(l);
            k = (j & (IDX_MASK >> s_q)) << s_q;
        end

        twiddle_gen_par_rom_bank #(
            .N  (N),
            .DW (DW)
        ) u_rom (
            .clk     (clk),
            .rst     (rst),
            .en      (issue),
            .addr    (k),
            .rd_data (lane_data[l])
        );
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            bus.coeff_out[l*2*DW +: 2*DW] = lane_data[l];
        end
    end

    assign bus.coeff_valid = valid_q;
    assign bus.coeff_last  = last_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_twiddle_gen_par.sv
// Scoreboard bench for twiddle_gen_par: driver pushes expected beats, negedge monitor checks them.
module tb_twiddle_gen_par;
    import twiddle_gen_par_pkg::*;

    localparam int unsigned BEATS = TW_N / (2 * TW_LANES);
    localparam int unsigned OW    = TW_LANES * 2 * TW_DW;
    localparam real         SCALE = 1023.0;

    typedef struct {
        logic [OW-1:0] coeff;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    twiddle_gen_par_if #(.LOG2N(TW_LOG2N), .LANES(TW_LANES), .DW(TW_DW)) bus ();

    twiddle_gen_par #(
        .N     (TW_N),
        .LOG2N (TW_LOG2N),
        .LANES (TW_LANES),
        .DW    (TW_DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rnd(real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    // Reference: lane l of beat b uses W^k, k = (j mod M) * 2^s, j = b*LANES + l, M = N / 2^(s+1).
    function automatic logic [OW-1:0] model_beat(int unsigned s, int unsigned b);
        logic [OW-1:0] v;
        int unsigned   j;
        int unsigned   m;
        int unsigned   k;
        real           ang;
        logic [31:0]   re;
        logic [31:0]   im;
        v = '0;
        for (int unsigned l = 0; l < TW_LANES; l++) begin
            j   = b * TW_LANES + l;
            m   = TW_N / (2 ** (s + 1));
            k   = (j % m) * (2 ** s);
            ang = 2.0 * 3.141592653589793 * real'(k) / real'(TW_N);
            re  = rnd(SCALE * $cos(ang));
            im  = rnd(-SCALE * $sin(ang));
            v[l*2*TW_DW +: 2*TW_DW] = {re[TW_DW-1:0], im[TW_DW-1:0]};
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.coeff_valid) begin
                check("beat_expected", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    check("coeff", bus.coeff_out, sb[0].coeff);
                    check("last", bus.coeff_last, sb[0].last);
                    if (!bus.hold) void'(sb.pop_front());
                end
            end else begin
                check("last_idle", bus.coeff_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int unsigned stage, input bit accept);
        exp_t e;
        bus.start = 1'b1;
        bus.stage = TW_LOG2N'(stage);
        if (accept) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                e.coeff = model_beat(stage, b);
                e.last  = (b == BEATS - 1);
                sb.push_back(e);
            end
        end
        tick();
        bus.start = 1'b0;
        check("err_on_start", bus.err, accept ? 0 : 1);
    endtask

    task automatic wait_done(input bit rand_hold);
        int unsigned guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            bus.hold = rand_hold ? ($urandom_range(3) == 0) : 1'b0;
            tick();
            guard++;
        end
        bus.hold = 1'b0;
        check("seq_complete", sb.size(), 0);
        check("busy_done", bus.busy, 0);
        check("valid_done", bus.coeff_valid, 0);
    endtask

    logic [OW-1:0] k0_all;

    initial begin
        for (int unsigned l = 0; l < TW_LANES; l++) k0_all[l*2*TW_DW +: 2*TW_DW] = {11'd1023, 11'd0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stage = '0;
        bus.hold  = 1'b0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.coeff_valid, 0);
        check("rst_last", bus.coeff_last, 0);
        check("rst_err", bus.err, 0);
        check("rst_coeff", bus.coeff_out, 0);
        rst = 1'b0;
        tick();

        // Stage 0 straight through
        start_seq(0, 1'b1);
        check("busy_run", bus.busy, 1);
        wait_done(1'b0);

        // Stage 6: every lane W^0
        start_seq(6, 1'b1);
        tick();
        check("stage6_beat0", bus.coeff_out, k0_all);
        wait_done(1'b0);

        // Stage 3: stride 8, wraps every two beats
        start_seq(3, 1'b1);
        wait_done(1'b0);

        // Hold three cycles on beat 5
        start_seq(0, 1'b1);
        repeat (6) tick();
        bus.hold = 1'b1;
        check("hold_valid_in", bus.coeff_valid, 1);
        repeat (3) begin
            tick();
            check("hold_valid", bus.coeff_valid, 1);
        end
        bus.hold = 1'b0;
        wait_done(1'b0);

        // Start while busy, then start with an out-of-range stage
        start_seq(0, 1'b1);
        repeat (4) tick();
        start_seq(3, 1'b0);
        check("busy_after_reject", bus.busy, 1);
        tick();
        check("err_pulse_end", bus.err, 0);
        wait_done(1'b0);
        start_seq(7, 1'b0);
        check("bad_stage_idle", bus.busy, 0);
        tick();
        check("err_pulse_end2", bus.err, 0);

        // Reset mid-sequence at beat 8
        start_seq(0, 1'b1);
        repeat (9) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.coeff_valid, 0);
        check("abort_last", bus.coeff_last, 0);
        start_seq(2, 1'b1);
        wait_done(1'b1);

        // Start together with hold in IDLE
        bus.hold = 1'b1;
        start_seq(1, 1'b1);
        repeat (2) tick();
        check("hold_start_no_beat", bus.coeff_valid, 0);
        bus.hold = 1'b0;
        wait_done(1'b1);

        // Randomised stages, holds and rejected starts
        for (int unsigned it = 0; it < 10; it++) begin
            if ($urandom_range(2) == 0) start_seq($urandom_range(127, 7), 1'b0);
            start_seq($urandom_range(6), 1'b1);
            wait_done(1'b1);
        end

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
